// File: rtl/apb_addr_demux_pkg.sv
// Shared helpers for the APB address demultiplexer.
//   strb_width : number of byte strobes for a given data width
//   idx_width  : width of a port index for a given port count (minimum 1)
package apb_addr_demux_pkg;

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_rule_decoder.sv
// Combinational address-rule decoder.
//   addr_i        : address to decode
//   addr_start_i  : per-rule inclusive start address (packed, rule 0 in LSBs)
//   addr_end_i    : per-rule exclusive end address (packed, rule 0 in LSBs)
//   idx_o         : matching rule index, or DEFAULT_IDX when nothing matches
//   valid_o       : some rule matched
//   err_o         : nothing matched and default routing is disabled
module apb_addr_rule_decoder
  import apb_addr_demux_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int NO_MST_PORTS = 5,
  parameter int EN_DEFAULT   = 1,
  parameter int DEFAULT_IDX  = 0,
  parameter int IDX_W        = idx_width(NO_MST_PORTS)
) (
  input  logic [ADDR_WIDTH-1:0]              addr_i,
  input  logic [NO_MST_PORTS*ADDR_WIDTH-1:0] addr_start_i,
  input  logic [NO_MST_PORTS*ADDR_WIDTH-1:0] addr_end_i,
  output logic [IDX_W-1:0]                   idx_o,
  output logic                               valid_o,
  output logic                               err_o
);

  // Scan from the highest rule down so the lowest matching index is the
  // last assignment and therefore wins on overlap.
  always_comb begin
    idx_o   = IDX_W'(DEFAULT_IDX);
    valid_o = 1'b0;
    for (int i = NO_MST_PORTS - 1; i >= 0; i--) begin
      if ((addr_i >= addr_start_i[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (addr_i <  addr_end_i[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

  assign err_o = ~valid_o & (EN_DEFAULT == 0);

endmodule

// File: rtl/apb_addr_demux.sv
// APB 1-to-N demultiplexer with integrated address decoder.
//   clk_i, rst_i                : clock, asynchronous active-high reset
//   addr_start_i / addr_end_i   : per-port address rules [start, end)
//   slv_*                       : upstream APB request in, response out
//   mst_*                       : downstream APB ports; request broadcast,
//                                 one-hot psel, response muxed back
//   sel_o                       : port index currently routed
//   dec_err_o                   : current transfer hit no rule (no default)
// The port index decoded in the setup phase is held for the whole access
// phase so routing cannot move while a slave inserts wait states.
module apb_addr_demux
  import apb_addr_demux_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NO_MST_PORTS = 5,
  parameter int EN_DEFAULT   = 1,
  parameter int DEFAULT_IDX  = 0,
  parameter int IDX_W        = idx_width(NO_MST_PORTS)
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic [NO_MST_PORTS*ADDR_WIDTH-1:0]               addr_start_i,
  input  logic [NO_MST_PORTS*ADDR_WIDTH-1:0]               addr_end_i,
  input  logic [ADDR_WIDTH-1:0]                            slv_paddr_i,
  input  logic [2:0]                                       slv_pprot_i,
  input  logic                                             slv_psel_i,
  input  logic                                             slv_penable_i,
  input  logic                                             slv_pwrite_i,
  input  logic [DATA_WIDTH-1:0]                            slv_pwdata_i,
  input  logic [strb_width(DATA_WIDTH)-1:0]                slv_pstrb_i,
  output logic                                             slv_pready_o,
  output logic [DATA_WIDTH-1:0]                            slv_prdata_o,
  output logic                                             slv_pslverr_o,
  output logic [NO_MST_PORTS*ADDR_WIDTH-1:0]               mst_paddr_o,
  output logic [NO_MST_PORTS*3-1:0]                        mst_pprot_o,
  output logic [NO_MST_PORTS-1:0]                          mst_psel_o,
  output logic [NO_MST_PORTS-1:0]                          mst_penable_o,
  output logic [NO_MST_PORTS-1:0]                          mst_pwrite_o,
  output logic [NO_MST_PORTS*DATA_WIDTH-1:0]               mst_pwdata_o,
  output logic [NO_MST_PORTS*strb_width(DATA_WIDTH)-1:0]   mst_pstrb_o,
  input  logic [NO_MST_PORTS-1:0]                          mst_pready_i,
  input  logic [NO_MST_PORTS*DATA_WIDTH-1:0]               mst_prdata_i,
  input  logic [NO_MST_PORTS-1:0]                          mst_pslverr_i,
  output logic [IDX_W-1:0]                                 sel_o,
  output logic                                             dec_err_o
);

  logic [IDX_W-1:0] idx_p0;
  logic             dec_valid_p0;
  logic             dec_err_p0;
  logic             err_p0;
  logic [IDX_W-1:0] idx_p1;
  logic             err_p1;
  logic             setup_phase;
  logic             access_phase;
  logic [IDX_W-1:0] sel_cur;
  logic             err_cur;

  apb_addr_rule_decoder #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .NO_MST_PORTS (NO_MST_PORTS),
    .EN_DEFAULT   (EN_DEFAULT),
    .DEFAULT_IDX  (DEFAULT_IDX),
    .IDX_W        (IDX_W)
  ) u_decoder (
    .addr_i       (slv_paddr_i),
    .addr_start_i (addr_start_i),
    .addr_end_i   (addr_end_i),
    .idx_o        (idx_p0),
    .valid_o      (dec_valid_p0),
    .err_o        (dec_err_p0)
  );

  assign err_p0       = dec_err_p0 & ~dec_valid_p0;
  assign setup_phase  = slv_psel_i & ~slv_penable_i;
  assign access_phase = slv_psel_i &  slv_penable_i;

  // ---- stage p0 -> p1: capture the setup-phase decode for the access phase
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_p1 <= IDX_W'(DEFAULT_IDX);
      err_p1 <= 1'b0;
    end else if (setup_phase) begin
      idx_p1 <= idx_p0;
      err_p1 <= err_p0;
    end
  end

  // ---- routing: live decode outside the access phase, held decode inside
  assign sel_cur   = access_phase ? idx_p1 : idx_p0;
  assign err_cur   = access_phase ? err_p1 : err_p0;
  assign sel_o     = sel_cur;
  assign dec_err_o = err_cur;

  assign mst_paddr_o   = {NO_MST_PORTS{slv_paddr_i}};
  assign mst_pprot_o   = {NO_MST_PORTS{slv_pprot_i}};
  assign mst_penable_o = {NO_MST_PORTS{slv_penable_i}};
  assign mst_pwrite_o  = {NO_MST_PORTS{slv_pwrite_i}};
  assign mst_pwdata_o  = {NO_MST_PORTS{slv_pwdata_i}};
  assign mst_pstrb_o   = {NO_MST_PORTS{slv_pstrb_i}};

  always_comb begin
    mst_psel_o = '0;
    for (int i = 0; i < NO_MST_PORTS; i++) begin
      mst_psel_o[i] = slv_psel_i & ~err_cur & (sel_cur == IDX_W'(i));
    end
  end

  // An undecodable transfer is answered locally with an error in its first
  // access cycle; no downstream slave is ever selected for it.
  always_comb begin
    slv_pready_o  = 1'b0;
    slv_prdata_o  = '0;
    slv_pslverr_o = 1'b0;
    if (slv_psel_i) begin
      if (err_cur) begin
        slv_pready_o  = slv_penable_i;
        slv_pslverr_o = slv_penable_i;
      end else begin
        for (int i = 0; i < NO_MST_PORTS; i++) begin
          if (sel_cur == IDX_W'(i)) begin
            slv_pready_o  = mst_pready_i[i];
            slv_prdata_o  = mst_prdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            slv_pslverr_o = mst_pslverr_i[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_addr_demux.sv
// Testbench for apb_addr_demux: two instances share the same stimulus, one
// with default routing enabled (d_*) and one with it disabled (e_*).
// Rules: port i owns [i*6553, (i+1)*6553) in a 15-bit address space.
module tb_apb_addr_demux;

  localparam int AW  = 15;
  localparam int DW  = 32;
  localparam int N   = 5;
  localparam int SW  = 4;
  localparam int IW  = 3;
  localparam int REG = 6553;

  typedef struct {
    int          port;
    logic [DW-1:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N*AW-1:0] addr_start, addr_end;
  logic [AW-1:0]   paddr;
  logic [2:0]      pprot;
  logic            psel, penable, pwrite;
  logic [DW-1:0]   pwdata;
  logic [SW-1:0]   pstrb;
  logic [N-1:0]    mst_pready, mst_pslverr;
  logic [N*DW-1:0] mst_prdata;

  logic            d_pready, d_pslverr, d_err;
  logic [DW-1:0]   d_prdata;
  logic [N*AW-1:0] d_mpaddr;
  logic [N*3-1:0]  d_mpprot;
  logic [N-1:0]    d_mpsel, d_mpenable, d_mpwrite;
  logic [N*DW-1:0] d_mpwdata;
  logic [N*SW-1:0] d_mpstrb;
  logic [IW-1:0]   d_sel;

  logic            e_pready, e_pslverr, e_err;
  logic [DW-1:0]   e_prdata;
  logic [N*AW-1:0] e_mpaddr;
  logic [N*3-1:0]  e_mpprot;
  logic [N-1:0]    e_mpsel, e_mpenable, e_mpwrite;
  logic [N*DW-1:0] e_mpwdata;
  logic [N*SW-1:0] e_mpstrb;
  logic [IW-1:0]   e_sel;

  apb_addr_demux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_MST_PORTS(N),
                   .EN_DEFAULT(1), .DEFAULT_IDX(0)) dut_d (
    .clk_i(clk), .rst_i(rst), .addr_start_i(addr_start), .addr_end_i(addr_end),
    .slv_paddr_i(paddr), .slv_pprot_i(pprot), .slv_psel_i(psel),
    .slv_penable_i(penable), .slv_pwrite_i(pwrite), .slv_pwdata_i(pwdata),
    .slv_pstrb_i(pstrb), .slv_pready_o(d_pready), .slv_prdata_o(d_prdata),
    .slv_pslverr_o(d_pslverr), .mst_paddr_o(d_mpaddr), .mst_pprot_o(d_mpprot),
    .mst_psel_o(d_mpsel), .mst_penable_o(d_mpenable), .mst_pwrite_o(d_mpwrite),
    .mst_pwdata_o(d_mpwdata), .mst_pstrb_o(d_mpstrb), .mst_pready_i(mst_pready),
    .mst_prdata_i(mst_prdata), .mst_pslverr_i(mst_pslverr), .sel_o(d_sel),
    .dec_err_o(d_err));

  apb_addr_demux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_MST_PORTS(N),
                   .EN_DEFAULT(0), .DEFAULT_IDX(0)) dut_e (
    .clk_i(clk), .rst_i(rst), .addr_start_i(addr_start), .addr_end_i(addr_end),
    .slv_paddr_i(paddr), .slv_pprot_i(pprot), .slv_psel_i(psel),
    .slv_penable_i(penable), .slv_pwrite_i(pwrite), .slv_pwdata_i(pwdata),
    .slv_pstrb_i(pstrb), .slv_pready_o(e_pready), .slv_prdata_o(e_prdata),
    .slv_pslverr_o(e_pslverr), .mst_paddr_o(e_mpaddr), .mst_pprot_o(e_mpprot),
    .mst_psel_o(e_mpsel), .mst_penable_o(e_mpenable), .mst_pwrite_o(e_mpwrite),
    .mst_pwdata_o(e_mpwdata), .mst_pstrb_o(e_mpstrb), .mst_pready_i(mst_pready),
    .mst_prdata_i(mst_prdata), .mst_pslverr_i(mst_pslverr), .sel_o(e_sel),
    .dec_err_o(e_err));

  // Reference decode: region number by division, out-of-range falls back.
  function automatic int ref_port(input logic [AW-1:0] a, input bit en_def,
                                  output bit err);
    int p;
    p = int'(a) / REG;
    if (p < N) begin
      err = 1'b0;
      return p;
    end
    err = !en_def;
    return 0;
  endfunction

  // One transfer checked against the default-routing instance.
  task automatic do_xfer(input logic [AW-1:0] a, input bit wr,
                         input logic [DW-1:0] wd, input logic [SW-1:0] st,
                         input int waits, input logic [AW-1:0] a_acc,
                         input bit b2b, input bit fix_rd,
                         input logic [DW-1:0] rd_val);
    int         p;
    bit         e;
    exp_t       x;
    exp_t       got;
    logic [N-1:0] oh;
    p = ref_port(a, 1'b1, e);
    oh = '0;
    oh[p] = 1'b1;
    for (int k = 0; k < N; k++) mst_prdata[k*DW +: DW] = $urandom;
    mst_pslverr = N'($urandom);
    if (fix_rd) begin
      mst_prdata[p*DW +: DW] = rd_val;
      mst_pslverr[p] = 1'b0;
    end
    mst_pready = '0;
    x.port  = p;
    x.rdata = mst_prdata[p*DW +: DW];
    x.err   = mst_pslverr[p];
    sb.push_back(x);
    paddr = a; pwrite = wr; pwdata = wd; pstrb = st; pprot = 3'($urandom);
    psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    checks++;
    if (d_mpsel !== oh)
      $display("FAIL setup_psel: got %b expected %b (addr %h)", d_mpsel, oh, a);
    if (d_mpsel !== oh) errors++;
    checks++;
    if (d_sel !== IW'(p) || d_err !== 1'b0) begin
      errors++;
      $display("FAIL setup_sel: got sel %0d err %b expected sel %0d err 0", d_sel, d_err, p);
    end
    @(posedge clk); #1;
    penable = 1'b1;
    paddr = a_acc;
    for (int w = 0; w <= waits; w++) begin
      mst_pready = (w == waits) ? '1 : '0;
      @(negedge clk);
      checks++;
      if (d_mpsel !== oh || d_sel !== IW'(p)) begin
        errors++;
        $display("FAIL access_route: got psel %b sel %0d expected psel %b sel %0d", d_mpsel, d_sel, oh, p);
      end
      checks++;
      if (d_mpaddr[p*AW +: AW] !== paddr || d_mpwdata[p*DW +: DW] !== pwdata ||
          d_mpstrb[p*SW +: SW] !== pstrb || d_mpwrite[p] !== pwrite ||
          d_mpenable[p] !== 1'b1 || d_mpprot[p*3 +: 3] !== pprot) begin
        errors++;
        $display("FAIL broadcast: got addr %h wdata %h strb %h expected addr %h wdata %h strb %h",
                 d_mpaddr[p*AW +: AW], d_mpwdata[p*DW +: DW], d_mpstrb[p*SW +: SW], paddr, pwdata, pstrb);
      end
      checks++;
      if (d_pready !== (w == waits)) begin
        errors++;
        $display("FAIL pready: got %b expected %b at access cycle %0d", d_pready, (w == waits), w + 1);
      end
      if (w == waits) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
          got = sb.pop_front();
          if (d_prdata !== got.rdata || d_pslverr !== got.err) begin
            errors++;
            $display("FAIL response: got prdata %h pslverr %b expected prdata %h pslverr %b (port %0d)",
                     d_prdata, d_pslverr, got.rdata, got.err, got.port);
          end
        end
      end
      @(posedge clk); #1;
    end
    mst_pready = '0;
    if (!b2b) begin
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; paddr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (d_pready !== 1'b0 || d_prdata !== '0 || d_pslverr !== 1'b0 || d_mpsel !== '0) begin
      errors++;
      $display("FAIL reset_idle_d: got pready %b prdata %h pslverr %b psel %b expected all 0",
               d_pready, d_prdata, d_pslverr, d_mpsel);
    end
    checks++;
    if (e_pready !== 1'b0 || e_mpsel !== '0 || d_sel !== '0 || d_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_e: got pready %b psel %b sel %0d err %b expected 0 0 0 0",
               e_pready, e_mpsel, d_sel, d_err);
    end
    // Straight into an access phase: only the reset value of the held index applies.
    paddr = 15'd20000; psel = 1'b1; penable = 1'b1;
    #1;
    checks++;
    if (d_sel !== '0 || e_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: got sel %0d err %b expected sel 0 err 0", d_sel, e_err);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write;
    do_xfer(15'h0000, 1'b1, 32'hDEADBEEF, 4'hF, 0, 15'h0000, 1'b0, 1'b0, '0);
  endtask

  task automatic test_read_wait;
    do_xfer(15'h1999, 1'b0, '0, 4'h0, 3, 15'h1999, 1'b0, 1'b1, 32'h12345678);
  endtask

  task automatic test_default_route;
    do_xfer(15'h7FFE, 1'b0, '0, 4'h0, 1, 15'h7FFE, 1'b0, 1'b0, '0);
  endtask

  task automatic test_dec_err;
    exp_t x;
    exp_t got;
    x.port = -1; x.rdata = '0; x.err = 1'b1;
    sb.push_back(x);
    mst_pready = '0;
    mst_prdata = {N{32'hA5A5A5A5}};
    mst_pslverr = '0;
    paddr = 15'h7FFE; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    checks++;
    if (e_mpsel !== '0 || e_err !== 1'b1) begin
      errors++;
      $display("FAIL decerr_setup: got psel %b err %b expected psel 0 err 1", e_mpsel, e_err);
    end
    checks++;
    if (d_err !== 1'b0 || d_mpsel !== 5'b00001) begin
      errors++;
      $display("FAIL default_setup: got psel %b err %b expected psel 00001 err 0", d_mpsel, d_err);
    end
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    checks++;
    got = sb.pop_front();
    if (e_pready !== 1'b1 || e_pslverr !== got.err || e_prdata !== got.rdata || e_mpsel !== '0) begin
      errors++;
      $display("FAIL decerr_resp: got pready %b pslverr %b prdata %h psel %b expected 1 1 0 0",
               e_pready, e_pslverr, e_prdata, e_mpsel);
    end
    checks++;
    if (d_pready !== 1'b0 || d_err !== 1'b0) begin
      errors++;
      $display("FAIL default_wait: got pready %b err %b expected pready 0 err 0", d_pready, d_err);
    end
    mst_pready = '1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; mst_pready = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_addr_change;
    do_xfer(15'h0000, 1'b0, '0, 4'h0, 2, 15'h7000, 1'b0, 1'b0, '0);
  endtask

  task automatic test_back_to_back;
    do_xfer(15'd13200, 1'b1, 32'h11111111, 4'h3, 0, 15'd13200, 1'b1, 1'b0, '0);
    do_xfer(15'd26300, 1'b0, '0,           4'h0, 1, 15'd26300, 1'b1, 1'b0, '0);
    do_xfer(15'd6552,  1'b1, 32'h22222222, 4'hC, 0, 15'd6552,  1'b1, 1'b0, '0);
    do_xfer(15'd19659, 1'b0, '0,           4'h0, 2, 15'd19659, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_mid;
    mst_pready = '0;
    paddr = 15'h7FFE; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    checks++;
    if (e_err !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre_err: got %b expected 1", e_err);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (e_err !== 1'b0 || e_sel !== '0 || e_pready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_err: got err %b sel %0d pready %b expected 0 0 0", e_err, e_sel, e_pready);
    end
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    paddr = 15'd19659; psel = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    checks++;
    if (d_sel !== 3'd3) begin
      errors++;
      $display("FAIL rstmid_pre_sel: got %0d expected 3", d_sel);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (d_sel !== '0 || d_err !== 1'b0 || d_mpsel !== 5'b00001) begin
      errors++;
      $display("FAIL rstmid_sel: got sel %0d err %b psel %b expected sel 0 err 0 psel 00001",
               d_sel, d_err, d_mpsel);
    end
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [AW-1:0] a;
    logic [AW-1:0] a_acc;
    for (int t = 0; t < 1000; t++) begin
      a = AW'($urandom_range(0, 32767));
      a_acc = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 32767)) : a;
      do_xfer(a, 1'($urandom), $urandom, SW'($urandom), $urandom_range(0, 3),
              a_acc, 1'($urandom), 1'b0, '0);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      addr_start[i*AW +: AW] = AW'(i * REG);
      addr_end[i*AW +: AW]   = AW'((i + 1) * REG);
    end
    pprot = '0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
    mst_pready = '0; mst_pslverr = '0; mst_prdata = '0;
    test_reset();
    test_write();
    test_read_wait();
    test_default_route();
    test_dec_err();
    test_addr_change();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_addr_demux.md
Name: apb_addr_demux

Overview:
- Single-slave-port to NoMstPorts-master-port APB demultiplexer with an integrated address decoder.
- Routes each APB transfer to the master port whose address rule contains PADDR.
- Response signals (pready, prdata, pslverr) are returned from the same port.
- Sits between an APB bridge or master and multiple peripheral slaves; the decoded port index is latched for the access phase.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width; strobe width is DATA_WIDTH/8. DATA_WIDTH must be a multiple of 8.
- NO_MST_PORTS, 5, number of master (downstream) ports; must be at least 2.
- EN_DEFAULT, 1, when 1, unmatched addresses route to DEFAULT_IDX; when 0, they get an internal error response.
- DEFAULT_IDX, 0, default port index; must be less than NO_MST_PORTS.
- IDX_W, max(1, clog2(NO_MST_PORTS)), width of the port index (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- addr_start_i  in  NO_MST_PORTS*ADDR_WIDTH  rule start address per port; inclusive.
- addr_end_i  in  NO_MST_PORTS*ADDR_WIDTH  rule end address per port; exclusive.
- slv_paddr_i  in  ADDR_WIDTH  upstream address.
- slv_pprot_i  in  3  upstream protection.
- slv_psel_i  in  1  upstream select.
- slv_penable_i  in  1  upstream enable.
- slv_pwrite_i  in  1  upstream write.
- slv_pwdata_i  in  DATA_WIDTH  upstream write data.
- slv_pstrb_i  in  DATA_WIDTH/8  upstream write strobes.
- slv_pready_o  out  1  upstream ready.
- slv_prdata_o  out  DATA_WIDTH  upstream read data.
- slv_pslverr_o  out  1  upstream slave error.
- mst_paddr_o, mst_pprot_o, mst_penable_o, mst_pwrite_o, mst_pwdata_o, mst_pstrb_o  out  per-port packed vectors  broadcast copies of the slave-side request signals.
- mst_psel_o  out  NO_MST_PORTS  one-hot select.
- mst_pready_i  in  NO_MST_PORTS  per-port ready.
- mst_prdata_i  in  NO_MST_PORTS*DATA_WIDTH  per-port read data.
- mst_pslverr_i  in  NO_MST_PORTS  per-port error.
- sel_o  out  IDX_W  index currently routed (debug).
- dec_err_o  out  1  current transfer has no matching rule and EN_DEFAULT=0.

Behaviour:
- Decode:
  - Rule i matches when start_i <= paddr < end_i, using unsigned comparison.
  - On overlapping rules, the lowest index wins.
  - No match: if EN_DEFAULT=1, route to DEFAULT_IDX and keep dec_err low. If EN_DEFAULT=0, set dec_err.
- Setup phase (psel=1, penable=0):
  - Use the combinational decode result.
  - The decoded index and error flag are registered on the rising clk_i edge.
- Access phase (psel=1, penable=1):
  - Use the registered index and error flag.
  - Routing stays stable even if paddr changes.
- Idle (psel=0): sel_o shows the combinational decode; all mst_psel_o are low.
- Request path is combinational, zero latency:
  - paddr, pprot, penable, pwrite, pwdata and pstrb are broadcast to every port.
  - mst_psel_o[sel] = slv_psel_i; all other bits are 0.
  - When dec_err is active, all mst_psel_o bits are 0.
- Response path is combinational from the selected port: slv_pready_o, slv_prdata_o and slv_pslverr_o.
  - Applies when psel=1, no decode error, and the access phase uses the registered index.
- Decode error (EN_DEFAULT=0) during the access phase:
  - slv_pready_o=1, slv_pslverr_o=1, slv_prdata_o=0.
  - Completes in exactly one access cycle.
- When psel=0: slv_pready_o=0, slv_prdata_o=0, slv_pslverr_o=0.
- Wait states: the selected slave may hold pready low for any number of cycles. The registered index is held until pready=1 and the transfer ends.
- Back-to-back transfers (setup immediately after access) re-decode in the new setup cycle.
- Reset (asynchronous):
  - Registered index clears to DEFAULT_IDX and the error flag clears to 0.
  - Outputs are combinational functions of inputs and registers. No output is registered, so nothing beyond this must reset.
  - A transfer in flight during reset is aborted; upstream and downstream must reset together.

Decomposition:
- Package apb_addr_demux_pkg: strobe-width function and index-width function.
- Sub-module apb_addr_rule_decoder: purely combinational. Inputs are addr, the rule vectors, EN_DEFAULT and DEFAULT_IDX; outputs are idx, valid and err.

Test Plan:
All scenarios use ADDR_WIDTH=15, NO_MST_PORTS=5, region size 6553; rule i spans [i*6553, (i+1)*6553).
- Write to 0x0000, pwdata=0xDEADBEEF, pstrb=0xF → only mst_psel_o[0] high; port 0 sees identical paddr, pwdata and pstrb; completes when port 0 pready=1.
- Read from 0x1999 (6553) with port 1 returning prdata=0x12345678, pslverr=0 after 3 wait states → slave port gets 0x12345678 with pready on the 4th access cycle; sel_o=1.
- Read from 0x7FFE (beyond 32765), EN_DEFAULT=1 → routed to port 0, dec_err_o=0.
- Same address, EN_DEFAULT=0 → no mst_psel_o set; response pready=1, pslverr=1, prdata=0 in the first access cycle.
- paddr changed from 0x0000 to 0x7000 during the access phase → port 0 remains selected until pready.
- Assert rst_i mid-access → sel_o immediately reads DEFAULT_IDX and dec_err_o=0; 1000 random transfers then complete with zero mismatches against the per-port reference model.
